// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx serializer among NUM_REQ byte producers.
// Define UART_ARB_PKT_LOCK_EN to add i_Req_Lock, which keeps a locked requester's packet contiguous.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
`ifdef UART_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]   i_Req_Lock,
`endif
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic [ID_W-1:0]      o_Grant_Id
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_SETTLE} state_t;
    state_t          r_State;
    logic [ID_W-1:0] r_Last, w_Pick, w_Idx;
    logic            w_Elig;
    assign o_Grant_Id = r_Last;
    assign w_Elig = |i_Req_DV && !i_Tx_Active && !i_Tx_Done;
    // walk from farthest to nearest so the nearest requester after r_Last wins
    always_comb begin
        w_Pick = r_Last;
        w_Idx  = r_Last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_Idx = ID_W'((int'(r_Last) + i) % NUM_REQ);
            w_Pick = i_Req_DV[w_Idx] ? w_Idx : w_Pick;
        end
`ifdef UART_ARB_PKT_LOCK_EN
        w_Pick = (i_Req_Lock[r_Last] && i_Req_DV[r_Last]) ? r_Last : w_Pick;
`endif
    end
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State   <= S_IDLE;
            r_Last    <= ID_W'(NUM_REQ - 1);
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            o_Busy    <= 1'b0;
        end else begin
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            case (r_State)
                S_IDLE: if (w_Elig) begin
                    r_State   <= S_WAIT_DONE;
                    r_Last    <= w_Pick;
                    o_Req_Ack <= NUM_REQ'(1) << w_Pick;
                    o_Tx_DV   <= 1'b1;
                    o_Tx_Byte <= i_Req_Byte[{w_Pick, 3'b000} +: 8];
                    o_Busy    <= 1'b1;
                end
                S_WAIT_DONE: if (i_Tx_Done) r_State <= S_SETTLE;
                // hold until the two-cycle done pulse is over so uart_tx has left cleanup
                S_SETTLE: if (!i_Tx_Done) begin
                    r_State <= S_IDLE;
                    o_Busy  <= 1'b0;
                end
                default: begin
                    r_State <= S_IDLE;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
